// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader_pkg
// Description : Shared types and constants for the ROM loading path.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    // Width shared with the sys block's rom_remain counter.
    localparam int c_byte_cnt_w = 24;

    localparam logic [7:0] c_pad_byte_default = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [c_byte_cnt_w-1:0] sat_inc(input logic [c_byte_cnt_w-1:0] v);
        return (&v) ? v : v + c_byte_cnt_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_sdram_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_sdram_writer_if
// Description : SDRAM loader-port write request/acknowledge bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_sdram_writer_if #(
    parameter int ADDR_W = 22
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, output mem_din, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_din, output mem_ack);
endinterface
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : word_fifo
// Description : Small first-word-fall-through FIFO with wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_sdram_writer.sv
`default_nettype none
// ============================================================================
// Module      : rom_sdram_writer
// Description : Packs the SPI ROM byte stream into 16-bit little-endian words
//               and writes them to SDRAM through a small word FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_sdram_writer
    import rom_loader_pkg::*;
#(
    parameter int              FIFO_DEPTH = 8,
    parameter int              ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]      PAD_BYTE   = c_pad_byte_default
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rom_loading,
    input  logic [7:0]              rom_do,
    input  logic                    rom_do_valid,
    rom_sdram_writer_if.master      mem,
    output logic                    busy,
    output logic                    load_done,
    output logic [c_byte_cnt_w-1:0] byte_count,
    output logic                    overflow
);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_pending;
    logic [7:0]              r_latched;
    logic [c_byte_cnt_w-1:0] r_byte_count;
    logic                    r_overflow;

    logic                    r_req;
    logic [ADDR_W-1:0]       r_addr;
    logic [15:0]             r_din;

    logic                    w_start;
    logic                    w_accept;
    logic                    w_ending;
    logic                    w_fifo_push;
    logic [15:0]             w_fifo_din;
    logic                    w_fifo_pop;
    logic [15:0]             w_fifo_dout;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;

    assign w_start    = (r_state == ST_IDLE) && rom_loading;
    assign w_accept   = (r_state == ST_LOAD) && rom_do_valid;
    assign w_ending   = (r_state == ST_LOAD) && !rom_loading;
    assign w_fifo_pop = !r_req && !w_fifo_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fifo_push = 1'b0;
        w_fifo_din  = {rom_do, r_latched};
        busy        = 1'b0;
        load_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rom_loading) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (w_accept && r_pending) begin
                    w_fifo_push = 1'b1;
                    w_fifo_din  = {rom_do, r_latched};
                end else if (w_ending && w_accept) begin
                    w_fifo_push = 1'b1;
                    w_fifo_din  = {PAD_BYTE, rom_do};
                end else if (w_ending && r_pending) begin
                    w_fifo_push = 1'b1;
                    w_fifo_din  = {PAD_BYTE, r_latched};
                end
                if (w_ending) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (w_fifo_empty && !r_req) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                load_done   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte packing and status; the upstream cannot stall, so a full FIFO drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
            r_pending    <= 1'b0;
            r_latched    <= '0;
        end else if (w_start) begin
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte_count <= sat_inc(r_byte_count);
            end
            if (w_accept && !r_pending) begin
                r_latched <= rom_do;
            end
            if (w_ending) begin
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending <= !r_pending;
            end
            if (w_fifo_push && w_fifo_full && !w_fifo_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Write port: request held stable until acknowledged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            if (w_start) begin
                r_addr <= BASE_ADDR;
            end else if (r_req && mem.mem_ack) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_fifo_pop) begin
                r_req <= 1'b1;
                r_din <= w_fifo_dout;
            end else if (r_req && mem.mem_ack) begin
                r_req <= 1'b0;
            end
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_fifo_push),
        .din    (w_fifo_din),
        .pop    (w_fifo_pop),
        .dout   (w_fifo_dout),
        .empty  (w_fifo_empty),
        .full   (w_fifo_full)
    );

    assign mem.mem_req  = r_req;
    assign mem.mem_addr = r_addr;
    assign mem.mem_din  = r_din;
    assign byte_count   = r_byte_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rom_sdram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_sdram_writer
// Description : Scoreboard bench; two instances differ only in BASE_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_sdram_writer;
    import rom_loader_pkg::*;

    localparam int              c_aw    = 22;
    localparam logic [c_aw-1:0] c_base1 = 22'h100000;

    logic        clk          = 1'b0;
    logic        resetn       = 1'b0;
    logic        rom_loading  = 1'b0;
    logic [7:0]  rom_do       = 8'h00;
    logic        rom_do_valid = 1'b0;
    logic        busy0, busy1, done0, done1, ovf0, ovf1;
    logic [23:0] cnt0, cnt1;

    int          checks    = 0;
    int          failures  = 0;
    int          ack_delay = 1;
    bit          ack_hold  = 1'b0;
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;
    logic [37:0] q0[$];
    logic [37:0] q1[$];
    logic [7:0]  bytes[64];

    rom_sdram_writer_if #(.ADDR_W(c_aw)) m0 ();
    rom_sdram_writer_if #(.ADDR_W(c_aw)) m1 ();

    rom_sdram_writer #(.FIFO_DEPTH(8), .ADDR_W(c_aw), .BASE_ADDR(22'h0), .PAD_BYTE(8'hFF)) u_dut0 (
        .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
        .rom_do_valid(rom_do_valid), .mem(m0), .busy(busy0), .load_done(done0),
        .byte_count(cnt0), .overflow(ovf0));

    rom_sdram_writer #(.FIFO_DEPTH(8), .ADDR_W(c_aw), .BASE_ADDR(c_base1), .PAD_BYTE(8'hFF)) u_dut1 (
        .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
        .rom_do_valid(rom_do_valid), .mem(m1), .busy(busy1), .load_done(done1),
        .byte_count(cnt1), .overflow(ovf1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SDRAM responders: ack arrives ack_delay cycles after the request rises.
    initial begin : resp0
        int c;
        c = 0;
        m0.mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            m0.mem_ack = 1'b0;
            if (m0.mem_req && !ack_hold) begin
                c++;
                if (c >= ack_delay) begin m0.mem_ack = 1'b1; c = 0; end
            end else if (!m0.mem_req) c = 0;
        end
    end

    initial begin : resp1
        int c;
        c = 0;
        m1.mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            m1.mem_ack = 1'b0;
            if (m1.mem_req && !ack_hold) begin
                c++;
                if (c >= ack_delay) begin m1.mem_ack = 1'b1; c = 0; end
            end else if (!m1.mem_req) c = 0;
        end
    end

    initial begin : mon0
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (resetn && m0.mem_req && m0.mem_ack) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut0_unexpected_write: got %0h@%0h expected none", m0.mem_din, m0.mem_addr);
                end else begin
                    e = q0.pop_front();
                    check("dut0_addr", 32'(m0.mem_addr), 32'(e[37:16]));
                    check("dut0_data", 32'(m0.mem_din), 32'(e[15:0]));
                end
            end
            if (done0) done_cnt0++;
        end
    end

    initial begin : mon1
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (resetn && m1.mem_req && m1.mem_ack) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dut1_unexpected_write: got %0h@%0h expected none", m1.mem_din, m1.mem_addr);
                end else begin
                    e = q1.pop_front();
                    check("dut1_addr", 32'(m1.mem_addr), 32'(e[37:16]));
                    check("dut1_data", 32'(m1.mem_din), 32'(e[15:0]));
                end
            end
            if (done1) done_cnt1++;
        end
    end

    // Little-endian word model, odd tail padded with 8'hFF, at most limit words.
    task automatic expect_words(input int nb, input int limit);
        int nw;
        nw = (nb + 1) / 2;
        for (int w = 0; w < nw && w < limit; w++) begin
            logic [7:0] lo, hi;
            lo = bytes[2*w];
            hi = (2*w + 1 < nb) ? bytes[2*w+1] : 8'hFF;
            q0.push_back({22'(w), hi, lo});
            q1.push_back({c_base1 + 22'(w), hi, lo});
        end
    endtask

    task automatic start_load();
        @(posedge clk); #1;
        rom_loading = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit fall);
        rom_do       = b;
        rom_do_valid = 1'b1;
        if (fall) rom_loading = 1'b0;
        @(posedge clk); #1;
        rom_do_valid = 1'b0;
    endtask

    task automatic end_load();
        rom_loading = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic finish_load(input string name, input int nb, input bit exp_ovf);
        int d0, d1, t;
        d0 = done_cnt0;
        d1 = done_cnt1;
        t  = 0;
        while (done_cnt0 == d0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt0 == d0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no load_done expected one within 2000 cycles", name);
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done0"}, 32'(done_cnt0 - d0), 32'd1);
        check({name, "_done1"}, 32'(done_cnt1 - d1), 32'd1);
        check({name, "_count0"}, 32'(cnt0), 32'(nb));
        check({name, "_count1"}, 32'(cnt1), 32'(nb));
        check({name, "_ovf0"}, 32'(ovf0), 32'(exp_ovf));
        check({name, "_ovf1"}, 32'(ovf1), 32'(exp_ovf));
        check({name, "_busy0"}, 32'(busy0), 32'd0);
        check({name, "_pending0"}, 32'(q0.size()), 32'd0);
        check({name, "_pending1"}, 32'(q1.size()), 32'd0);
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(m0.mem_req), 32'd0);
        check("rst_addr1", 32'(m1.mem_addr), 32'd0);
        check("rst_din", 32'(m0.mem_din), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        resetn = 1'b1;

        // Even-length load, fast ack.
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        expect_words(4, 99);
        ack_delay = 1;
        start_load();
        check("t1_busy", 32'(busy0), 32'd1);
        for (int i = 0; i < 4; i++) drive_byte(bytes[i], 1'b0);
        end_load();
        finish_load("t1", 4, 1'b0);

        // Odd-length load, padded tail.
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
        expect_words(3, 99);
        start_load();
        for (int i = 0; i < 3; i++) drive_byte(bytes[i], 1'b0);
        end_load();
        finish_load("t2", 3, 1'b0);

        // Back-to-back bytes with slow ack.
        for (int i = 0; i < 10; i++) bytes[i] = 8'(8'h30 + i);
        expect_words(10, 99);
        ack_delay = 5;
        start_load();
        for (int i = 0; i < 10; i++) drive_byte(bytes[i], 1'b0);
        end_load();
        finish_load("t3", 10, 1'b0);

        // Ack withheld: one in flight, eight queued, the tenth word drops.
        for (int i = 0; i < 40; i++) bytes[i] = 8'(i * 3 + 7);
        expect_words(40, 9);
        ack_hold = 1'b1;
        start_load();
        for (int i = 0; i < 40; i++) begin
            drive_byte(bytes[i], 1'b0);
            check("t4_ovf_progress", 32'(ovf0), 32'(i >= 19));
        end
        end_load();
        ack_delay = 1;
        ack_hold  = 1'b0;
        finish_load("t4", 40, 1'b1);

        // Final byte arrives in the same cycle rom_loading falls.
        for (int i = 0; i < 5; i++) bytes[i] = 8'(i + 1);
        expect_words(5, 99);
        start_load();
        for (int i = 0; i < 4; i++) drive_byte(bytes[i], 1'b0);
        drive_byte(bytes[4], 1'b1);
        finish_load("t5", 5, 1'b0);

        // Reset while a request is outstanding in FLUSH.
        ack_hold = 1'b1;
        start_load();
        for (int i = 0; i < 4; i++) drive_byte(8'(8'h90 + i), 1'b0);
        end_load();
        repeat (2) @(posedge clk);
        #1;
        check("t6_req_before", 32'(m0.mem_req), 32'd1);
        check("t6_busy_before", 32'(busy0), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_req_abort", 32'(m0.mem_req), 32'd0);
        check("t6_busy_abort", 32'(busy0), 32'd0);
        check("t6_count_abort", 32'(cnt0), 32'd0);
        check("t6_req1_abort", 32'(m1.mem_req), 32'd0);
        check("t6_addr1_abort", 32'(m1.mem_addr), 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        resetn    = 1'b1;
        ack_hold  = 1'b0;
        ack_delay = 2;
        bytes[0] = 8'h5A; bytes[1] = 8'hA5;
        expect_words(2, 99);
        start_load();
        for (int i = 0; i < 2; i++) drive_byte(bytes[i], 1'b0);
        end_load();
        finish_load("t6", 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
